// File: rtl/exe_stage_module_pkg.sv
// Shared widths, ALU/shift encodings and small arithmetic helpers for the ARM execute stage.
package exe_stage_module_pkg;

  localparam int ADDRESS_LEN          = 32;
  localparam int REGISTER_LEN         = 32;
  localparam int REG_ADDRESS_LEN      = 4;
  localparam int EXECUTE_COMMAND_LEN  = 4;
  localparam int SIGNED_IMMEDIATE_LEN = 24;
  localparam int SHIFT_OPERAND_LEN    = 12;

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } alu_cmd_e;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_type_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  function automatic logic [31:0] ror32(input logic [31:0] value, input logic [4:0] amount);
    logic [63:0] doubled;
    doubled = {value, value} >> amount;
    return doubled[31:0];
  endfunction

  function automatic logic add_overflow(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    return (a[31] == b[31]) && (r[31] != a[31]);
  endfunction

  function automatic logic sub_overflow(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    return (a[31] != b[31]) && (r[31] != a[31]);
  endfunction

endpackage

// File: rtl/exe_stage_module_if.sv
// ID->EX operands and EX->MEM/IF/hazard results of the execute stage, bundled as one interface.
interface exe_stage_module_if;
  import exe_stage_module_pkg::*;

  logic                            freeze;
  logic [ADDRESS_LEN-1:0]          PC_in;
  logic                            mem_read_en_in;
  logic                            mem_write_en_in;
  logic                            wb_enable_in;
  logic                            immediate_in;
  logic                            branch_taken_in;
  logic                            status_write_enable_in;
  logic [EXECUTE_COMMAND_LEN-1:0]  execute_command_in;
  logic [REGISTER_LEN-1:0]         reg_file_in1;
  logic [REGISTER_LEN-1:0]         reg_file_in2;
  logic [REG_ADDRESS_LEN-1:0]      dest_reg_in;
  logic [SIGNED_IMMEDIATE_LEN-1:0] signed_immediate_in;
  logic [SHIFT_OPERAND_LEN-1:0]    shift_operand_in;
  logic [3:0]                      status_reg_in;

  logic                            branch_taken_out;
  logic [ADDRESS_LEN-1:0]          branch_address_out;
  logic [REG_ADDRESS_LEN-1:0]      ex_dest_out;
  logic                            ex_wb_en_out;
  logic [3:0]                      status_reg_out;
  logic [REGISTER_LEN-1:0]         alu_result_out;
  logic [REGISTER_LEN-1:0]         store_value_out;
  logic [REG_ADDRESS_LEN-1:0]      dest_reg_out;
  logic                            mem_read_en_out;
  logic                            mem_write_en_out;
  logic                            wb_enable_out;

  modport master (
    output freeze, PC_in, mem_read_en_in, mem_write_en_in, wb_enable_in, immediate_in,
           branch_taken_in, status_write_enable_in, execute_command_in, reg_file_in1,
           reg_file_in2, dest_reg_in, signed_immediate_in, shift_operand_in, status_reg_in,
    input  branch_taken_out, branch_address_out, ex_dest_out, ex_wb_en_out, status_reg_out,
           alu_result_out, store_value_out, dest_reg_out, mem_read_en_out, mem_write_en_out,
           wb_enable_out
  );

  modport slave (
    input  freeze, PC_in, mem_read_en_in, mem_write_en_in, wb_enable_in, immediate_in,
           branch_taken_in, status_write_enable_in, execute_command_in, reg_file_in1,
           reg_file_in2, dest_reg_in, signed_immediate_in, shift_operand_in, status_reg_in,
    output branch_taken_out, branch_address_out, ex_dest_out, ex_wb_en_out, status_reg_out,
           alu_result_out, store_value_out, dest_reg_out, mem_read_en_out, mem_write_en_out,
           wb_enable_out
  );

endinterface

// File: rtl/exe_stage_module_val2_generator.sv
// Second ALU operand: memory offset, rotated 8-bit immediate, or shifted Rm.
module val2_generator
  import exe_stage_module_pkg::*;
(
  input  logic        mem_en,
  input  logic        immediate,
  input  logic [11:0] shift_operand,
  input  logic [31:0] rm,
  output logic [31:0] val2
);

  // Operand select; an immediate rotate amount is twice the 4-bit rotate field
  always_comb begin
    val2 = 32'd0;
    if (mem_en) begin
      val2 = {20'd0, shift_operand};
    end else if (immediate) begin
      val2 = ror32({24'd0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
    end else begin
      case (shift_type_e'(shift_operand[6:5]))
        SHIFT_LSL: val2 = rm << shift_operand[11:7];
        SHIFT_LSR: val2 = rm >> shift_operand[11:7];
        SHIFT_ASR: val2 = $unsigned($signed(rm) >>> shift_operand[11:7]);
        SHIFT_ROR: val2 = ror32(rm, shift_operand[11:7]);
        default:   val2 = rm;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage_module.sv
// ARM execute stage: ALU with NZCV generation, branch target, status register and EX/MEM register.
module exe_stage_module
  import exe_stage_module_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  exe_stage_module_if.slave ex
);

  logic [31:0] val2_s;
  logic [31:0] alu_result_s;
  logic [32:0] sum_s;
  logic        carry_add_s;
  logic        nz_update_s;
  nzcv_t       flags_s;
  nzcv_t       status_r;
  logic [31:0] alu_result_r;
  logic [31:0] store_value_r;
  logic [3:0]  dest_reg_r;
  logic        mem_read_en_r;
  logic        mem_write_en_r;
  logic        wb_enable_r;

  val2_generator u_val2 (
    .mem_en        (ex.mem_read_en_in | ex.mem_write_en_in),
    .immediate     (ex.immediate_in),
    .shift_operand (ex.shift_operand_in),
    .rm            (ex.reg_file_in2),
    .val2          (val2_s)
  );

  // ALU; subtraction is Rn + ~val2 + carry-in so the carry-out is directly NOT borrow
  always_comb begin
    alu_result_s = 32'd0;
    sum_s        = 33'd0;
    carry_add_s  = 1'b0;
    nz_update_s  = 1'b1;
    flags_s      = nzcv_t'(ex.status_reg_in);
    case (ex.execute_command_in)
      CMD_MOV: alu_result_s = val2_s;
      CMD_MVN: alu_result_s = ~val2_s;
      CMD_ADD, CMD_ADC: begin
        carry_add_s  = (ex.execute_command_in == CMD_ADC) ? ex.status_reg_in[1] : 1'b0;
        sum_s        = {1'b0, ex.reg_file_in1} + {1'b0, val2_s} + {32'd0, carry_add_s};
        alu_result_s = sum_s[31:0];
        flags_s.c    = sum_s[32];
        flags_s.v    = add_overflow(ex.reg_file_in1, val2_s, sum_s[31:0]);
      end
      CMD_SUB, CMD_SBC: begin
        carry_add_s  = (ex.execute_command_in == CMD_SBC) ? ex.status_reg_in[1] : 1'b1;
        sum_s        = {1'b0, ex.reg_file_in1} + {1'b0, ~val2_s} + {32'd0, carry_add_s};
        alu_result_s = sum_s[31:0];
        flags_s.c    = sum_s[32];
        flags_s.v    = sub_overflow(ex.reg_file_in1, val2_s, sum_s[31:0]);
      end
      CMD_AND: alu_result_s = ex.reg_file_in1 & val2_s;
      CMD_ORR: alu_result_s = ex.reg_file_in1 | val2_s;
      CMD_EOR: alu_result_s = ex.reg_file_in1 ^ val2_s;
      default: begin
        alu_result_s = 32'd0;
        nz_update_s  = 1'b0;
      end
    endcase
    if (nz_update_s) begin
      flags_s.n = alu_result_s[31];
      flags_s.z = (alu_result_s == 32'd0);
    end else begin
      flags_s.n = ex.status_reg_in[3];
      flags_s.z = ex.status_reg_in[2];
    end
  end

  // Status register; freeze blocks the update even with S set
  always_ff @(posedge clk) begin
    if (!rst) begin
      status_r <= nzcv_t'(4'b0000);
    end else if (ex.status_write_enable_in && !ex.freeze) begin
      status_r <= flags_s;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_result_r   <= 32'd0;
      store_value_r  <= 32'd0;
      dest_reg_r     <= 4'd0;
      mem_read_en_r  <= 1'b0;
      mem_write_en_r <= 1'b0;
      wb_enable_r    <= 1'b0;
    end else if (!ex.freeze) begin
      alu_result_r   <= alu_result_s;
      store_value_r  <= ex.reg_file_in2;
      dest_reg_r     <= ex.dest_reg_in;
      mem_read_en_r  <= ex.mem_read_en_in;
      mem_write_en_r <= ex.mem_write_en_in;
      wb_enable_r    <= ex.wb_enable_in;
    end
  end

  assign ex.branch_taken_out   = ex.branch_taken_in;
  assign ex.branch_address_out = ex.PC_in + {{6{ex.signed_immediate_in[23]}}, ex.signed_immediate_in, 2'b00};
  assign ex.ex_dest_out        = ex.dest_reg_in;
  assign ex.ex_wb_en_out       = ex.wb_enable_in;
  assign ex.status_reg_out     = status_r;
  assign ex.alu_result_out     = alu_result_r;
  assign ex.store_value_out    = store_value_r;
  assign ex.dest_reg_out       = dest_reg_r;
  assign ex.mem_read_en_out    = mem_read_en_r;
  assign ex.mem_write_en_out   = mem_write_en_r;
  assign ex.wb_enable_out      = wb_enable_r;

endmodule

// File: tb/tb_exe_stage_module.sv
// Table-driven, scoreboarded bench for the execute stage, plus freeze/reset/branch sequences.
module tb_exe_stage_module;
  import exe_stage_module_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_stage_module_if bus ();

  exe_stage_module dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus)
  );

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic        mr, mw, wb, imm, s;
    logic [31:0] rn, rm;
    logic [11:0] sop;
    logic [3:0]  sr_in, dest;
    logic [31:0] exp_res;
    logic [3:0]  exp_status;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] res, store;
    logic [3:0]  status, dest;
    logic        mr, mw, wb;
  } exp_t;

  vec_t vecs[20];
  exp_t sb_q[$];
  exp_t last_exp;
  exp_t zero_exp;
  vec_t fv;
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic frz);
    bus.freeze                 = frz;
    bus.execute_command_in     = v.cmd;
    bus.mem_read_en_in         = v.mr;
    bus.mem_write_en_in        = v.mw;
    bus.wb_enable_in           = v.wb;
    bus.immediate_in           = v.imm;
    bus.status_write_enable_in = v.s;
    bus.reg_file_in1           = v.rn;
    bus.reg_file_in2           = v.rm;
    bus.shift_operand_in       = v.sop;
    bus.status_reg_in          = v.sr_in;
    bus.dest_reg_in            = v.dest;
    bus.PC_in                  = 32'd0;
    bus.signed_immediate_in    = 24'd0;
    bus.branch_taken_in        = 1'b0;
  endtask

  function automatic exp_t exp_of(input vec_t v);
    exp_t e;
    e.name   = v.name;
    e.res    = v.exp_res;
    e.store  = v.rm;
    e.status = v.exp_status;
    e.dest   = v.dest;
    e.mr     = v.mr;
    e.mw     = v.mw;
    e.wb     = v.wb;
    return e;
  endfunction

  // Wait for the capturing edge, then compare the registered outputs against the oldest expectation
  task automatic step_and_compare();
    exp_t e;
    @(posedge clk);
    #1;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb_q.pop_front();
      check({e.name, " alu_result"}, bus.alu_result_out, e.res);
      check({e.name, " status"}, {28'd0, bus.status_reg_out}, {28'd0, e.status});
      check({e.name, " store"}, bus.store_value_out, e.store);
      check({e.name, " dest"}, {28'd0, bus.dest_reg_out}, {28'd0, e.dest});
      check({e.name, " ctrl"}, {29'd0, bus.mem_read_en_out, bus.mem_write_en_out, bus.wb_enable_out},
            {29'd0, e.mr, e.mw, e.wb});
      last_exp = e;
    end
  endtask

  initial begin
    //          name            cmd      mr    mw    wb    imm   s     rn             rm             sop      sr_in    dest   exp_res        exp_status
    vecs[0]  = '{"adds_imm",    4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd5,         32'd0,         12'h003, 4'b0000, 4'd1,  32'd8,         4'b0000};
    vecs[1]  = '{"subs_zero",   4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd7,         32'd7,         12'h000, 4'b0000, 4'd2,  32'd0,         4'b0110};
    vecs[2]  = '{"adds_ovf",    4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h7FFFFFFF,  32'd0,         12'h001, 4'b0000, 4'd3,  32'h80000000,  4'b1001};
    vecs[3]  = '{"mov_rot4",    4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,         32'd0,         12'h4FF, 4'b0000, 4'd4,  32'hFF000000,  4'b1001};
    vecs[4]  = '{"ldr",         4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000,      32'd0,         12'h004, 4'b0000, 4'd5,  32'h1004,      4'b1001};
    vecs[5]  = '{"str",         4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2000,      32'hDEADBEEF,  12'h010, 4'b0000, 4'd6,  32'h2010,      4'b1001};
    vecs[6]  = '{"movs_lsl4",   4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0,         32'd1,         12'h200, 4'b0010, 4'd7,  32'h10,        4'b0010};
    vecs[7]  = '{"movs_asr4",   4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0,         32'h80000000,  12'h240, 4'b0000, 4'd8,  32'hF8000000,  4'b1000};
    vecs[8]  = '{"movs_lsr31",  4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0,         32'h80000000,  12'hFA0, 4'b0001, 4'd9,  32'd1,         4'b0001};
    vecs[9]  = '{"movs_ror1",   4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0,         32'd1,         12'h0E0, 4'b0000, 4'd10, 32'h80000000,  4'b1000};
    vecs[10] = '{"adcs_carry",  4'b0011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF,  32'd0,         12'h000, 4'b0010, 4'd11, 32'd0,         4'b0110};
    vecs[11] = '{"sbcs",        4'b0101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd10,        32'd0,         12'h003, 4'b0000, 4'd12, 32'd6,         4'b0010};
    vecs[12] = '{"cmp_borrow",  4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd3,         32'd0,         12'h005, 4'b0000, 4'd13, 32'hFFFFFFFE,  4'b1000};
    vecs[13] = '{"and_nos",     4'b0110, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hF0F0,      32'd0,         12'h0FF, 4'b0000, 4'd14, 32'hF0,        4'b1000};
    vecs[14] = '{"orrs",        4'b0111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hF00,       32'd0,         12'h00F, 4'b0011, 4'd15, 32'hF0F,       4'b0011};
    vecs[15] = '{"eors",        4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFF,        32'd0,         12'h00F, 4'b0000, 4'd0,  32'hF0,        4'b0000};
    vecs[16] = '{"mvns",        4'b1001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0,         32'd0,         12'h000, 4'b0000, 4'd1,  32'hFFFFFFFF,  4'b1000};
    vecs[17] = '{"invalid",     4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234,      32'h5678,      12'h000, 4'b0101, 4'd2,  32'd0,         4'b0101};
    vecs[18] = '{"mov_rot30",   4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,         32'd0,         12'hF01, 4'b0000, 4'd3,  32'd4,         4'b0101};
    vecs[19] = '{"adds_rot2",   4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0,         32'd0,         12'h1FF, 4'b0000, 4'd4,  32'hC000003F,  4'b1000};

    zero_exp = '{"reset", 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst = 1'b0;
    drive(vecs[0], 1'b0);
    @(posedge clk);
    @(negedge clk);
    sb_q.push_back(zero_exp);
    step_and_compare();
    @(negedge clk);
    rst = 1'b1;

    // Table vectors, one per cycle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vecs[i], 1'b0);
      #1;
      check({vecs[i].name, " ex_dest"}, {28'd0, bus.ex_dest_out}, {28'd0, vecs[i].dest});
      check({vecs[i].name, " ex_wb"}, {31'd0, bus.ex_wb_en_out}, {31'd0, vecs[i].wb});
      sb_q.push_back(exp_of(vecs[i]));
      step_and_compare();
    end

    // Freeze during ADDS: everything holds, then the result lands on release
    fv = '{"freeze_adds", 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd1, 32'h55, 12'h001, 4'b0000, 4'd10, 32'd2, 4'b0000};
    @(negedge clk);
    drive(fv, 1'b1);
    sb_q.push_back('{"freeze_hold", last_exp.res, last_exp.store, last_exp.status, last_exp.dest,
                     last_exp.mr, last_exp.mw, last_exp.wb});
    step_and_compare();
    @(negedge clk);
    drive(fv, 1'b0);
    sb_q.push_back(exp_of(fv));
    step_and_compare();

    // Reset while frozen clears; freeze still honoured afterwards
    @(negedge clk);
    rst = 1'b0;
    fv = '{"frz_rst_adds", 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h7FFFFFFF, 32'h9, 12'h001, 4'b0000, 4'd6, 32'h80000000, 4'b1001};
    drive(fv, 1'b1);
    sb_q.push_back(zero_exp);
    step_and_compare();
    @(negedge clk);
    rst = 1'b1;
    sb_q.push_back('{"post_rst_frozen", 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0});
    step_and_compare();
    @(negedge clk);
    drive(fv, 1'b0);
    sb_q.push_back(exp_of(fv));
    step_and_compare();

    // Branch target: backward, wrap-around and forward
    @(negedge clk);
    bus.branch_taken_in     = 1'b1;
    bus.PC_in               = 32'd100;
    bus.signed_immediate_in = 24'hFFFFFE;
    #1;
    check("branch_back", bus.branch_address_out, 32'd92);
    check("branch_taken", {31'd0, bus.branch_taken_out}, 32'd1);
    bus.PC_in               = 32'hFFFFFFFC;
    bus.signed_immediate_in = 24'h000001;
    #1;
    check("branch_wrap", bus.branch_address_out, 32'd0);
    bus.PC_in               = 32'h1000;
    bus.signed_immediate_in = 24'h000010;
    bus.branch_taken_in     = 1'b0;
    #1;
    check("branch_fwd", bus.branch_address_out, 32'h1040);
    check("branch_not_taken", {31'd0, bus.branch_taken_out}, 32'd0);

    // Final reset clears all registered outputs
    @(negedge clk);
    rst = 1'b0;
    sb_q.push_back(zero_exp);
    step_and_compare();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
